ppe_rr_arb: RTL
===============

Name: ppe_rr_arb

Overview:
- Registered, parametrised programmable priority encoder / round-robin arbiter. Successor to the fixed-width, fixed-priority combinational encoders.
- Grants the first set request at or above a programmable pointer, wrapping to bit 0 if none. Presents a one-hot grant plus a binary index through a valid/ready handshake.
- In round-robin mode, the pointer advances past each accepted winner.
- Sits between the request-collection logic and the scheduler/consumer that accepts grants.

Parameters:
- W, 512, request/grant vector width; legal range 2..1024.
- IW, $clog2(W), index width (derived; do not override).
- RR_DEFAULT, 1, reset value of the rr_en mode bit.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active high.
- Req  in  W  request vector, sampled only in IDLE or on grant accept.
- ptr_ld  in  1  load programmable priority pointer this cycle.
- ptr_in  in  IW  new pointer value; values >= W are treated as 0.
- rr_en_ld  in  1  load the mode bit this cycle.
- rr_en_in  in  1  mode: 1 = round-robin pointer advance, 0 = fixed programmable priority.
- Gnt  out  W  registered one-hot grant.
- gnt_idx  out  IW  binary index of the Gnt bit.
- valid  out  1  Gnt/gnt_idx valid.
- ready  in  1  consumer accepts the grant when valid && ready.
- ptr  out  IW  current pointer (debug/status).

Behaviour:
- Reset (rst=1 at a clock edge): Gnt=0, gnt_idx=0, valid=0, ptr=0, rr_en=RR_DEFAULT. Reset mid-HOLD discards the pending grant with no pointer update.
- Arbitration function (combinational, on the ptr currently registered):
  - mask[i] = (i >= ptr).
  - hi = Req & mask.
  - If hi != 0, the winner is the lowest set bit of hi; otherwise the winner is the lowest set bit of Req.
  - found = |Req.
- FSM states: IDLE (valid=0) and HOLD (valid=1).
  - IDLE: if found, register Gnt/gnt_idx ← winner, valid ← 1, go to HOLD next cycle; otherwise stay in IDLE.
  - HOLD, ready=0: Gnt/gnt_idx/valid held stable. Changes on Req are ignored; the grant is sticky even if its request drops.
  - HOLD, ready=1 (accept): re-arbitrate in the same cycle using the post-accept pointer. If found, load the new winner and stay in HOLD (back-to-back, one grant per cycle). Otherwise valid ← 0 and go to IDLE.
- Latency: Req to valid is 1 cycle from IDLE. Throughput is one grant per cycle while ready=1.
- Pointer update, evaluated every cycle in this priority order:
  1. ptr_ld=1: ptr ← ptr_in (or 0 if ptr_in >= W).
  2. Else accept && rr_en: ptr ← (gnt_idx == W-1) ? 0 : gnt_idx+1.
  3. Else ptr holds.
- Pointer used by a same-cycle re-arbitration on accept:
  - If ptr_ld=1, it uses ptr_in (load wins).
  - Else if rr_en, it uses the advanced value.
  - Else it uses ptr.
- ptr_ld in IDLE: the arbitration in that same cycle uses the loaded value.
- rr_en_ld: rr_en ← rr_en_in at the edge; the new mode takes effect from the next cycle's accepts.
- Widths: index arithmetic is modulo W with explicit wrap, not modulo 2^IW, so W need not be a power of 2.
- Gnt is always exactly one-hot when valid=1 and all-zero when valid=0.

Decomposition:
- Package ppe_pkg holds:
  - clog2 helper function;
  - FSM state typedef (IDLE/HOLD);
  - W_MAX = 1024 constant.
- Sub-module ppe_lsb_pe #(W): combinational lowest-set-bit finder using the prefix-OR mask scheme. It outputs one-hot, binary index and found.
  - Two instances: one on hi, one on raw Req.
  - The top selects between them and owns all registers, the FSM and the pointer logic.

Test Plan:
- W=8, rr_en=1, ptr=0, Req=8'b1010_0100 held, ready=1 → grants idx 2, 5, 7, 2, … on consecutive cycles; ptr sequence 3, 6, 0, 3.
- W=8, rr_en=0, ptr_ld with ptr_in=6, Req=8'b0001_0011 → Gnt=8'b0000_0001 (wrap), ptr stays 6; then Req=8'b1101_0011 → Gnt=8'b0100_0000.
- Backpressure: Req=8'b0000_1000, ready=0 for 5 cycles, Req dropped to 0 at cycle 2 → Gnt=8'b0000_1000 and valid=1 stable all 5 cycles; on ready=1, valid→0 the next cycle, ptr=4.
- Simultaneous ptr_ld (ptr_in=1) and accept of idx 5 with rr_en=1 → ptr=1 (load wins); next winner is chosen from ptr 1.
- Reset mid-HOLD: valid=1, gnt_idx=3, rst=1 for 1 cycle with ready=1 → valid=0, Gnt=0, ptr=0 next cycle, no advance to 4.
- W=5 (non-power-of-2), rr_en=1, Req=5'b10001 → idx 0, 4, 0, …; ptr after idx 4 is 0; ptr_in=7 loads 0.

Source files
------------

// File: rtl/ppe_pkg.sv
// Shared types and helpers for the programmable priority encoder / round-robin arbiter.
`default_nettype none

package ppe_pkg;

  localparam int W_MAX = 1024;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_HOLD = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ppe_lsb_pe.sv
// Combinational lowest-set-bit finder: prefix-OR mask yields one-hot, binary index and found.
`default_nettype none

module ppe_lsb_pe #(
  parameter int W  = 8,
  parameter int IW = 3
) (
  input  logic [W-1:0]  vec,
  output logic [W-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          found
);

  // below[i] is set when any bit strictly below i is set
  logic [W-1:0] below;

  assign below[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < W; gi++) begin : g_prefix
      assign below[gi] = below[gi-1] | vec[gi-1];
    end
  endgenerate

  assign onehot = vec & ~below;
  assign found  = |vec;

  always_comb begin
    idx = '0;
    for (int i = 0; i < W; i++) begin
      if (onehot[i]) idx = idx | IW'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ppe_rr_arb.sv
// Registered programmable-priority / round-robin arbiter with valid/ready grant handshake.
`default_nettype none

module ppe_rr_arb
  import ppe_pkg::*;
#(
  parameter int W          = 512,
  parameter int IW         = clog2(W),
  parameter bit RR_DEFAULT = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  Req,
  input  logic          ptr_ld,
  input  logic [IW-1:0] ptr_in,
  input  logic          rr_en_ld,
  input  logic          rr_en_in,
  output logic [W-1:0]  Gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          valid,
  input  logic          ready,
  output logic [IW-1:0] ptr
);

  generate
    if (W < 2 || W > W_MAX) begin : g_param_check
      $error("ppe_rr_arb: W out of range");
    end
  endgenerate

  state_t        state;
  logic          rr_en;
  logic          accept;
  logic [IW-1:0] ptr_in_wrapped;
  logic [IW-1:0] ptr_adv;
  logic [IW-1:0] ptr_next;
  logic [W-1:0]  mask;
  logic [W-1:0]  hi;

  logic [W-1:0]  hi_oh,    raw_oh;
  logic [IW-1:0] hi_idx,   raw_idx;
  logic          hi_found, raw_found;

  logic [W-1:0]  win_oh;
  logic [IW-1:0] win_idx;

  assign valid  = (state == ST_HOLD);
  assign accept = valid & ready;

  // Explicit modulo-W wrap so non-power-of-2 widths behave
  assign ptr_in_wrapped = ({1'b0, ptr_in} >= (IW+1)'(W)) ? '0 : ptr_in;
  assign ptr_adv        = (gnt_idx == IW'(W-1)) ? '0 : gnt_idx + IW'(1);

  // The same-cycle arbitration pointer is exactly the next registered pointer
  always_comb begin
    ptr_next = ptr;
    if (ptr_ld)
      ptr_next = ptr_in_wrapped;
    else if (accept && rr_en)
      ptr_next = ptr_adv;
  end

  genvar gm;
  generate
    for (gm = 0; gm < W; gm++) begin : g_mask
      assign mask[gm] = (IW'(gm) >= ptr_next);
    end
  endgenerate

  assign hi = Req & mask;

  ppe_lsb_pe #(.W(W), .IW(IW)) u_pe_hi (
    .vec    (hi),
    .onehot (hi_oh),
    .idx    (hi_idx),
    .found  (hi_found)
  );

  ppe_lsb_pe #(.W(W), .IW(IW)) u_pe_raw (
    .vec    (Req),
    .onehot (raw_oh),
    .idx    (raw_idx),
    .found  (raw_found)
  );

  assign win_oh  = hi_found ? hi_oh  : raw_oh;
  assign win_idx = hi_found ? hi_idx : raw_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      Gnt     <= '0;
      gnt_idx <= '0;
      ptr     <= '0;
      rr_en   <= RR_DEFAULT;
    end else begin
      ptr <= ptr_next;
      if (rr_en_ld) rr_en <= rr_en_in;

      case (state)
        ST_IDLE: begin
          if (raw_found) begin
            Gnt     <= win_oh;
            gnt_idx <= win_idx;
            state   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (ready) begin
            if (raw_found) begin
              Gnt     <= win_oh;
              gnt_idx <= win_idx;
            end else begin
              Gnt     <= '0;
              gnt_idx <= '0;
              state   <= ST_IDLE;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          Gnt     <= '0;
          gnt_idx <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
